machine_irq_timer: RTL and testbench



---
 rtl/machine_irq_timer_pkg.sv | 34 +++
 rtl/machine_irq_timer_if.sv | 22 ++
 rtl/machine_irq_timer_irq_sync.sv | 25 ++
 rtl/machine_irq_timer.sv | 147 ++++++++++++++
 tb/tb_machine_irq_timer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/machine_irq_timer_pkg.sv
// Shared definitions for the machine-level interrupt timer: bus width,
// register offsets and the decoded register-select type.
package machine_irq_timer_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] IRQT_MTIME_LO    = 5'h00;
  localparam logic [4:0] IRQT_MTIME_HI    = 5'h04;
  localparam logic [4:0] IRQT_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] IRQT_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] IRQT_MSIP        = 5'h10;

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MSIP,
    SEL_NONE
  } reg_sel_e;

  // Decode a word address (byte address bits [4:2]) into a register select.
  function automatic reg_sel_e decodeAddr(input logic [2:0] wordAddr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (wordAddr == IRQT_MTIME_LO[4:2])         sel = SEL_MTIME_LO;
    else if (wordAddr == IRQT_MTIME_HI[4:2])    sel = SEL_MTIME_HI;
    else if (wordAddr == IRQT_MTIMECMP_LO[4:2]) sel = SEL_MTIMECMP_LO;
    else if (wordAddr == IRQT_MTIMECMP_HI[4:2]) sel = SEL_MTIMECMP_HI;
    else if (wordAddr == IRQT_MSIP[4:2])        sel = SEL_MSIP;
    return sel;
  endfunction

endpackage

// File: rtl/machine_irq_timer_if.sv
// Local data bus seen by the timer: single-cycle request, registered ack/rdata.
interface machine_irq_timer_if;
  import machine_irq_timer_pkg::*;

  logic            req_i;
  logic            we_i;
  logic [4:0]      addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            ack_o;
  logic [XLEN-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o
  );

endinterface

// File: rtl/machine_irq_timer_irq_sync.sv
// N-flop level synchronizer for an asynchronous interrupt line.
module machine_irq_timer_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the sampled level through the chain on every enabled cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= '0;
    end else if (en_i) begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/machine_irq_timer.sv
// Machine interrupt source: mtime/mtimecmp timer, msip software interrupt
// register and external interrupt synchronizer, feeding the CSR unit.
module machine_irq_timer
  import machine_irq_timer_pkg::*;
#(
  parameter int PRESCALE_DIV = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clk_en_i,
  machine_irq_timer_if.slave        bus,
  input  logic                      irq_ext_i,
  output logic                      irq_mtip_o,
  output logic                      irq_msip_o,
  output logic                      irq_meip_o
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE_DIV - 1);

  logic [15:0]     r_presc;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic [31:0]     r_shadowHi;
  logic            r_msip;
  logic            r_mtip;
  logic            r_ack;
  logic [XLEN-1:0] r_rdata;

  reg_sel_e        w_sel;
  logic            w_wr;
  logic            w_rd;
  logic            w_tick;
  logic [XLEN-1:0] w_rdVal;
  logic            w_unused;

  // Byte-lane bits carry no meaning for word-wide registers.
  assign w_unused = ^bus.addr_i[1:0];

  // Decode the access, the prescaler tick and the read-data mux.
  always_comb begin
    w_sel   = decodeAddr(bus.addr_i[4:2]);
    w_wr    = clk_en_i & bus.req_i & bus.we_i;
    w_rd    = clk_en_i & bus.req_i & ~bus.we_i;
    w_tick  = clk_en_i & (r_presc == PRESC_MAX);
    w_rdVal = '0;
    case (w_sel)
      SEL_MTIME_LO:    w_rdVal = r_mtime[31:0];
      SEL_MTIME_HI:    w_rdVal = r_shadowHi;
      SEL_MTIMECMP_LO: w_rdVal = r_mtimecmp[31:0];
      SEL_MTIMECMP_HI: w_rdVal = r_mtimecmp[63:32];
      SEL_MSIP:        w_rdVal = {{(XLEN-1){1'b0}}, r_msip};
      default:         w_rdVal = '0;
    endcase
  end

  // Free-running prescaler; mtime writes deliberately leave its phase alone.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_presc <= '0;
    end else if (clk_en_i) begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
    end
  end

  // mtime: a bus write to either half wins over the tick increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mtime <= '0;
    end else if (w_wr && (w_sel == SEL_MTIME_LO)) begin
      r_mtime[31:0] <= bus.wdata_i;
    end else if (w_wr && (w_sel == SEL_MTIME_HI)) begin
      r_mtime[63:32] <= bus.wdata_i;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp halves are plain read/write registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mtimecmp <= '1;
    end else if (w_wr && (w_sel == SEL_MTIMECMP_LO)) begin
      r_mtimecmp[31:0] <= bus.wdata_i;
    end else if (w_wr && (w_sel == SEL_MTIMECMP_HI)) begin
      r_mtimecmp[63:32] <= bus.wdata_i;
    end
  end

  // Reading the low half freezes the high half so a 64-bit read is coherent.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_shadowHi <= '0;
    end else if (w_rd && (w_sel == SEL_MTIME_LO)) begin
      r_shadowHi <= r_mtime[63:32];
    end
  end

  // Software interrupt bit; only bit 0 of the write data is kept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_msip <= 1'b0;
    end else if (w_wr && (w_sel == SEL_MSIP)) begin
      r_msip <= bus.wdata_i[0];
    end
  end

  // Timer pending is a registered level of the unsigned 64-bit compare.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mtip <= 1'b0;
    end else if (clk_en_i) begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  // Ack follows each request by one enabled cycle; rdata holds until the next read.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else if (clk_en_i) begin
      r_ack <= bus.req_i;
      if (w_rd) begin
        r_rdata <= w_rdVal;
      end
    end
  end

  // A pending ack is only presented on an enabled cycle.
  assign bus.ack_o   = r_ack & clk_en_i;
  assign bus.rdata_o = r_rdata;

  assign irq_mtip_o = r_mtip;
  assign irq_msip_o = r_msip;

  machine_irq_timer_irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_extSync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (clk_en_i),
    .d_i     (irq_ext_i),
    .q_o     (irq_meip_o)
  );

endmodule

// File: tb/tb_machine_irq_timer.sv
// Scoreboard bench: two timer instances (prescale 1 / sync 2 and prescale 4 /
// sync 3) share one stimulus stream and are checked against a behavioural model.
module tb_machine_irq_timer;

  logic clk_i;
  logic reset_i;
  logic clk_en_i;
  logic irq_ext_i;
  logic mtip1, msip1, meip1;
  logic mtip4, msip4, meip4;

  machine_irq_timer_if bus1 ();
  machine_irq_timer_if bus4 ();

  machine_irq_timer #(.PRESCALE_DIV(1), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i), .bus(bus1.slave),
    .irq_ext_i(irq_ext_i), .irq_mtip_o(mtip1), .irq_msip_o(msip1), .irq_meip_o(meip1)
  );

  machine_irq_timer #(.PRESCALE_DIV(4), .SYNC_STAGES(3)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i), .bus(bus4.slave),
    .irq_ext_i(irq_ext_i), .irq_mtip_o(mtip4), .irq_msip_o(msip4), .irq_meip_o(meip4)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d4;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = prescale 1, index 1 = prescale 4.
  logic [63:0] mMtime [2];
  logic [63:0] mCmp [2];
  logic [31:0] mShadow [2];
  logic [31:0] mLast [2];
  logic        mMsip [2];
  logic        mMtip [2];
  int          mEnCount [2];
  logic [3:0]  mHist;
  logic        pendAck;
  exp_t        expQ [$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int divOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] readModel(input int d, input logic [2:0] word);
    case (word)
      3'd0:    return mMtime[d][31:0];
      3'd1:    return mShadow[d];
      3'd2:    return mCmp[d][31:0];
      3'd3:    return mCmp[d][63:32];
      3'd4:    return {31'b0, mMsip[d]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mMtime[d]   = 64'd0;
      mCmp[d]     = '1;
      mShadow[d]  = 32'd0;
      mLast[d]    = 32'd0;
      mMsip[d]    = 1'b0;
      mMtip[d]    = 1'b0;
      mEnCount[d] = 0;
    end
    mHist   = 4'd0;
    pendAck = 1'b0;
    expQ.delete();
  endtask

  task automatic modelStep();
    logic        req;
    logic        we;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic [31:0] rv;
    logic        tick;
    logic        newMtip;
    logic        mtimeWritten;
    exp_t        e;
    req   = bus1.req_i;
    we    = bus1.we_i;
    word  = bus1.addr_i[4:2];
    wdata = bus1.wdata_i;
    for (int d = 0; d < 2; d++) begin
      newMtip = (mMtime[d] >= mCmp[d]);
      mEnCount[d]++;
      tick = ((mEnCount[d] % divOf(d)) == 0);
      rv = readModel(d, word);
      mtimeWritten = 1'b0;
      if (req && we) begin
        case (word)
          3'd0: begin mMtime[d][31:0]  = wdata; mtimeWritten = 1'b1; end
          3'd1: begin mMtime[d][63:32] = wdata; mtimeWritten = 1'b1; end
          3'd2: mCmp[d][31:0]  = wdata;
          3'd3: mCmp[d][63:32] = wdata;
          3'd4: mMsip[d] = wdata[0];
          default: ;
        endcase
      end else if (req && (word == 3'd0)) begin
        mShadow[d] = mMtime[d][63:32];
      end
      if (!mtimeWritten && tick) mMtime[d] = mMtime[d] + 64'd1;
      if (req && !we) mLast[d] = rv;
      mMtip[d] = newMtip;
    end
    if (req) begin
      e.d1 = mLast[0];
      e.d4 = mLast[1];
      expQ.push_back(e);
    end
    pendAck = req;
    mHist = {mHist[2:0], irq_ext_i};
  endtask

  // Reference model advances on every enabled clock and clears on reset.
  initial begin
    forever begin
      @(posedge clk_i or posedge reset_i);
      if (reset_i) modelReset();
      else if (clk_en_i) modelStep();
    end
  end

  // Monitor: compare ack, read data and interrupt levels midway through each cycle.
  initial begin
    logic expAck;
    exp_t e;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      expAck = pendAck && clk_en_i;
      checkOutput("ack1", bus1.ack_o, expAck);
      checkOutput("ack4", bus4.ack_o, expAck);
      if (expAck) begin
        checkOutput("ackQueued", (expQ.size() > 0), 1'b1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("rdata1", bus1.rdata_o, e.d1);
          checkOutput("rdata4", bus4.rdata_o, e.d4);
        end
      end
      checkOutput("mtip1", mtip1, mMtip[0]);
      checkOutput("mtip4", mtip4, mMtip[1]);
      checkOutput("msip1", msip1, mMsip[0]);
      checkOutput("msip4", msip4, mMsip[1]);
      checkOutput("meip1", meip1, mHist[1]);
      checkOutput("meip4", meip4, mHist[2]);
    end
  end

  task automatic applyStimulus(input logic en, input logic req, input logic we,
                               input logic [4:0] addr, input logic [31:0] wdata);
    clk_en_i     = en;
    bus1.req_i   = req;   bus4.req_i   = req;
    bus1.we_i    = we;    bus4.we_i    = we;
    bus1.addr_i  = addr;  bus4.addr_i  = addr;
    bus1.wdata_i = wdata; bus4.wdata_i = wdata;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack1"}, bus1.ack_o, 1'b0);
    checkOutput({tag, "_ack4"}, bus4.ack_o, 1'b0);
    checkOutput({tag, "_rdata1"}, bus1.rdata_o, 32'd0);
    checkOutput({tag, "_rdata4"}, bus4.rdata_o, 32'd0);
    checkOutput({tag, "_irqs1"}, {mtip1, msip1, meip1}, 3'b000);
    checkOutput({tag, "_irqs4"}, {mtip4, msip4, meip4}, 3'b000);
  endtask

  initial begin
    logic [2:0]  word;
    logic [4:0]  addr;
    logic [31:0] wdata;
    reset_i   = 1'b1;
    clk_en_i  = 1'b1;
    irq_ext_i = 1'b0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = 5'h00; bus1.wdata_i = 32'd0;
    bus4.req_i = 1'b0; bus4.we_i = 1'b0; bus4.addr_i = 5'h00; bus4.wdata_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #2;
    checkAllZero("reset");
    reset_i = 1'b0;

    // Idle count then read of mtime low
    idle(10);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 32'd0);
    idle(2);

    // Coherent 64-bit read across a carry out of the low half
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h00, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h04, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 32'd0);
    idle(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h04, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h04, 32'd0);
    idle(2);

    // Timer compare at 20, then cleared by raising the compare high half
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h04, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h00, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h08, 32'd20);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h0C, 32'd0);
    idle(25);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h0C, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h0C, 32'd0);
    idle(3);

    // Clock enable low for 7 cycles with a pending ack and ignored requests
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, i[0], 1'b1, 5'h00, 32'h55);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 32'd0);
    idle(2);

    // Software interrupt set via all-ones write, read back, then cleared
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h10, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h10, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h10, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h14, 32'd0);
    idle(2);

    // External interrupt pulse of 5 cycles
    irq_ext_i = 1'b1;
    idle(5);
    irq_ext_i = 1'b0;
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) irq_ext_i = ~irq_ext_i;
      word = 3'($urandom_range(0, 7));
      addr = {word, 2'($urandom_range(0, 3))};
      if (word == 3'd1 || word == 3'd3) wdata = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
      else if ($urandom_range(0, 3) == 0) wdata = $urandom;
      else wdata = $urandom_range(0, 60);
      applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), addr, wdata);
    end
    irq_ext_i = 1'b0;
    idle(4);

    // Reset in the middle of a read drops the ack and clears outputs at once
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h10, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h08, 32'd0);
    bus1.req_i = 1'b0;
    bus4.req_i = 1'b0;
    reset_i = 1'b1;
    #1;
    checkAllZero("midReset");
    repeat (2) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    idle(5);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
